// File: rtl/pipeline_hazard_sequencer_pkg.sv
// ============================================================================
// pipeline_hazard_sequencer_pkg : sequencer states, stage indices, mask helper
// Revision : 1.0
// ============================================================================
`default_nettype none

package pipeline_hazard_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_RUN        = 3'd0,
        ST_REDIR_WAIT = 3'd1,
        ST_SQUASH     = 3'd2,
        ST_DRAIN      = 3'd3,
        ST_HALTED     = 3'd4
    } seq_state_t;

    localparam int STG_IFID  = 0;
    localparam int STG_IDEX  = 1;
    localparam int STG_EXMEM = 2;
    localparam int STG_MEMWB = 3;

    // Mask with the lowest 'depth' bits set.
    function automatic logic [31:0] low_mask(input int unsigned depth);
        if (depth >= 32)
            low_mask = '1;
        else
            low_mask = (32'd1 << depth) - 32'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pipeline_hazard_sequencer_if.sv
// ============================================================================
// pipeline_hazard_sequencer_if : hazard events in, pipeline controls out
// Revision : 1.0
// ============================================================================
`default_nettype none

interface pipeline_hazard_sequencer_if #(
    parameter int NUM_STAGES = 4,
    parameter int CNT_WIDTH  = 16
);
    logic                  inst_busy;
    logic                  data_busy;
    logic                  data_hazard;
    logic                  branch_mispredict;
    logic                  jump_mispredict;
    logic                  halt_req;
    logic                  pc_write;
    logic                  redirect_take;
    logic                  redirect_sel;
    logic [NUM_STAGES-1:0] stage_write;
    logic [NUM_STAGES-1:0] stage_flush;
    logic                  halted;
    logic [CNT_WIDTH-1:0]  stall_cycles;
    logic [CNT_WIDTH-1:0]  flush_count;

    modport master (
        output inst_busy, data_busy, data_hazard,
               branch_mispredict, jump_mispredict, halt_req,
        input  pc_write, redirect_take, redirect_sel, stage_write,
               stage_flush, halted, stall_cycles, flush_count
    );

    modport slave (
        input  inst_busy, data_busy, data_hazard,
               branch_mispredict, jump_mispredict, halt_req,
        output pc_write, redirect_take, redirect_sel, stage_write,
               stage_flush, halted, stall_cycles, flush_count
    );
endinterface

`default_nettype wire

// File: rtl/pipeline_hazard_sequencer_sat_counter.sv
// ============================================================================
// sat_counter : up-counter that sticks at all-ones
// Revision : 1.0
// ============================================================================
`default_nettype none

module sat_counter #(
    parameter int CNT_WIDTH = 16
) (
    input  wire logic                 clk,
    input  wire logic                 reset_n,
    input  wire logic                 inc,
    input  wire logic                 clear,
    output logic      [CNT_WIDTH-1:0] count
);
    logic [CNT_WIDTH-1:0] count_q;
    logic [CNT_WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear)
            count_d = '0;
        else if (inc && (count_q != {CNT_WIDTH{1'b1}}))
            count_d = count_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            count_q <= '0;
        else
            count_q <= count_d;
    end

    assign count = count_q;
endmodule

`default_nettype wire

// File: rtl/pipeline_hazard_sequencer.sv
// ============================================================================
// pipeline_hazard_sequencer : PC/stage stall-flush sequencing with redirect,
//                             squash, drain/halt and saturating counters
// Revision : 1.0
// ============================================================================
`default_nettype none

module pipeline_hazard_sequencer
    import pipeline_hazard_sequencer_pkg::*;
#(
    parameter int NUM_STAGES = 4,
    parameter int JMP_FLUSH  = 1,
    parameter int BR_FLUSH   = 2,
    parameter int HAZ_STAGE  = 1,
    parameter int CNT_WIDTH  = 16
) (
    input  wire logic                clk,
    input  wire logic                reset_n,
    pipeline_hazard_sequencer_if.slave bus
);
    localparam int DRAIN_W = $clog2(NUM_STAGES) + 1;

    localparam logic [31:0] BR_FULL   = low_mask(BR_FLUSH);
    localparam logic [31:0] JMP_FULL  = low_mask(JMP_FLUSH);
    localparam logic [31:0] HOLD_FULL = low_mask(HAZ_STAGE);
    localparam logic [31:0] HAZ_FULL  = low_mask(HAZ_STAGE + 1) & ~low_mask(HAZ_STAGE);

    localparam logic [NUM_STAGES-1:0] BR_MASK   = BR_FULL[NUM_STAGES-1:0];
    localparam logic [NUM_STAGES-1:0] JMP_MASK  = JMP_FULL[NUM_STAGES-1:0];
    localparam logic [NUM_STAGES-1:0] HOLD_MASK = HOLD_FULL[NUM_STAGES-1:0];
    localparam logic [NUM_STAGES-1:0] HAZ_MASK  = HAZ_FULL[NUM_STAGES-1:0];
    localparam logic [NUM_STAGES-1:0] IF_MASK   = NUM_STAGES'(1) << STG_IFID;
    localparam logic [NUM_STAGES-1:0] ALL_MASK  = '1;

    seq_state_t           state_q, state_d;
    logic                 pend_q, pend_d;
    logic                 kind_q, kind_d;
    logic [DRAIN_W-1:0]   drain_q, drain_d;

    logic                  pc_write;
    logic                  redirect_take;
    logic                  redirect_sel;
    logic [NUM_STAGES-1:0] stage_write;
    logic [NUM_STAGES-1:0] stage_flush;
    logic                  halted;
    logic                  mispredict;
    logic                  stall_inc;

    assign mispredict = bus.branch_mispredict | bus.jump_mispredict;

    always_comb begin
        state_d       = state_q;
        pend_d        = pend_q;
        kind_d        = kind_q;
        drain_d       = drain_q;
        pc_write      = 1'b1;
        redirect_take = 1'b0;
        redirect_sel  = 1'b0;
        stage_write   = ALL_MASK;
        stage_flush   = '0;
        halted        = 1'b0;

        if (state_q == ST_HALTED) begin
            pc_write    = 1'b0;
            stage_write = '0;
            halted      = 1'b1;
        end else if (bus.data_busy) begin
            pc_write    = 1'b0;
            stage_write = '0;
            // A branch seen at any point during the freeze wins over a jump.
            if (mispredict) begin
                pend_d  = 1'b1;
                kind_d  = bus.branch_mispredict | (pend_q & kind_q);
                state_d = ST_REDIR_WAIT;
            end
        end else if (mispredict || (state_q == ST_REDIR_WAIT)) begin
            redirect_take = 1'b1;
            redirect_sel  = mispredict ? bus.branch_mispredict : kind_q;
            stage_flush   = redirect_sel ? BR_MASK : JMP_MASK;
            stage_write   = ~stage_flush;
            pend_d        = 1'b0;
            kind_d        = 1'b0;
            state_d       = (bus.inst_busy || (state_q == ST_SQUASH)) ? ST_SQUASH : ST_RUN;
        end else if (state_q == ST_DRAIN) begin
            pc_write    = 1'b0;
            stage_flush = IF_MASK;
            stage_write = ~IF_MASK;
            if (drain_q <= DRAIN_W'(1)) begin
                drain_d = '0;
                state_d = ST_HALTED;
            end else begin
                drain_d = drain_q - 1'b1;
            end
        end else if (bus.data_hazard) begin
            pc_write    = 1'b0;
            stage_flush = HAZ_MASK;
            stage_write = ~(HOLD_MASK | HAZ_MASK);
            if (state_q == ST_SQUASH)
                state_d = bus.inst_busy ? ST_SQUASH : ST_RUN;
        end else if (bus.inst_busy || (state_q == ST_SQUASH)) begin
            // In SQUASH the fetch landing as inst_busy falls is wrong-path and dropped.
            pc_write    = 1'b0;
            stage_flush = IF_MASK;
            stage_write = ~IF_MASK;
            if (state_q == ST_SQUASH)
                state_d = bus.inst_busy ? ST_SQUASH : ST_RUN;
        end else if (bus.halt_req) begin
            state_d = ST_DRAIN;
            drain_d = DRAIN_W'(NUM_STAGES - 1);
        end

        if (!reset_n) begin
            pc_write      = 1'b0;
            redirect_take = 1'b0;
            redirect_sel  = 1'b0;
            stage_write   = '0;
            stage_flush   = '0;
            halted        = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_RUN;
            pend_q  <= 1'b0;
            kind_q  <= 1'b0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            kind_q  <= kind_d;
            drain_q <= drain_d;
        end
    end

    assign stall_inc = reset_n & ~pc_write &
                       (state_q != ST_DRAIN) & (state_q != ST_HALTED);

    sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_stall_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (stall_inc),
        .clear   (1'b0),
        .count   (bus.stall_cycles)
    );

    sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_flush_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (redirect_take),
        .clear   (1'b0),
        .count   (bus.flush_count)
    );

    assign bus.pc_write      = pc_write;
    assign bus.redirect_take = redirect_take;
    assign bus.redirect_sel  = redirect_sel;
    assign bus.stage_write   = stage_write;
    assign bus.stage_flush   = stage_flush;
    assign bus.halted        = halted;
endmodule

`default_nettype wire
